// File: rtl/soc_rst_seq.sv
// soc_rst_seq: reset and boot-strap sequencer in front of cheshire_soc.
// Synchronises lock, DRAM calibration, the reset button and the boot-mode
// switches into soc_clk. The SoC reset is released only after lock,
// calibration (or its timeout) and a fixed hold window. The boot mode is
// captured on the release edge.

`timescale 1ns/1ps

module soc_rst_seq #(
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 50000,
    parameter int unsigned HoldCycles     = 256,
    parameter int unsigned CalibTimeout   = 2**24,
    parameter bit          BtnActiveLow   = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       locked_i,
    input  logic       calib_done_i,
    input  logic       btn_i,
    input  logic [1:0] boot_mode_i,
    output logic       soc_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       ready_o,
    output logic       calib_timeout_o
);

    // One counter serves both the calibration timeout and the hold window.
    localparam int unsigned MaxCnt = (HoldCycles > CalibTimeout) ? HoldCycles : CalibTimeout;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
    localparam int unsigned DbW    = $clog2(DebounceCycles) + 1;

    // Idle (not pressed) level of the button pin.
    localparam logic BtnRel = BtnActiveLow;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        WAIT_CALIB = 2'd1,
        HOLD       = 2'd2,
        RUN        = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SyncStages-1:0]      lock_sq;
    logic [SyncStages-1:0]      calib_sq;
    logic [SyncStages-1:0]      btn_sq;
    logic [SyncStages-1:0][1:0] boot_sq;

    logic       lock_s;
    logic       calib_s;
    logic       btn_s;
    logic [1:0] boot_s;

    // Shift every asynchronous input through its own flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sq  <= '0;
            calib_sq <= '0;
            // The button chain starts at its idle level so leaving reset
            // never looks like a press.
            btn_sq   <= {SyncStages{BtnRel}};
            boot_sq  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, which is what forms the chain.
            lock_sq  <= {lock_sq[SyncStages-2:0], locked_i};
            calib_sq <= {calib_sq[SyncStages-2:0], calib_done_i};
            btn_sq   <= {btn_sq[SyncStages-2:0], btn_i};
            boot_sq  <= {boot_sq[SyncStages-2:0], boot_mode_i};
        end
    end

    assign lock_s  = lock_sq[SyncStages-1];
    assign calib_s = calib_sq[SyncStages-1];
    assign btn_s   = btn_sq[SyncStages-1];
    assign boot_s  = boot_sq[SyncStages-1];

    // ------------------------------------------------------------------
    // Button debouncer
    // ------------------------------------------------------------------
    logic [DbW-1:0] db_cnt_q;
    logic           btn_db;
    logic           btn_db_q;
    logic           press_evt;

    // Count consecutive cycles where the synced button differs from the
    // accepted level. Any return to the accepted level restarts the count,
    // and for a single bit that is exactly "any change of the input".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q <= '0;
            btn_db   <= BtnRel;
            btn_db_q <= BtnRel;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbW'(DebounceCycles - 1)) begin
                btn_db   <= btn_s;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // Single-cycle pulse on the debounced idle-to-pressed transition only;
    // a release never produces an event.
    assign press_evt = (btn_db != BtnRel) && (btn_db_q == BtnRel);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            latch_boot;
    logic            set_timeout;

    // Next-state and control decode: lock loss beats a press, a press beats
    // the per-state rules; presses are ignored while waiting for DRAM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statements can leave one unassigned (no latch).
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        latch_boot  = 1'b0;
        set_timeout = 1'b0;

        if (state_q == WAIT_LOCK) begin
            if (lock_s) begin
                state_d = WAIT_CALIB;
            end
        end else if (!lock_s) begin
            state_d = WAIT_LOCK;
        end else if (press_evt && (state_q != WAIT_CALIB)) begin
            // Entering or re-entering HOLD restarts the hold window.
            state_d = HOLD;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                WAIT_CALIB: begin
                    // Calibration wins over a coincident timeout.
                    if (calib_s) begin
                        state_d = HOLD;
                    end else if ((CalibTimeout != 0) &&
                                 (cnt_q == CntW'(CalibTimeout - 1))) begin
                        state_d     = HOLD;
                        set_timeout = 1'b1;
                    end else begin
                        cnt_inc = (CalibTimeout != 0);
                    end
                end
                HOLD: begin
                    if (cnt_q == CntW'(HoldCycles - 1)) begin
                        state_d    = RUN;
                        latch_boot = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    // RUN holds until lock loss or a press.
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_clr = 1'b1;
        end
    end

    // State register and the shared cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Registered outputs: reset/ready follow the RUN state on the same edge
    // that enters or leaves it; boot mode is captured on the release edge and
    // the timeout flag is sticky until power-on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            soc_rst_no      <= 1'b0;
            ready_o         <= 1'b0;
            boot_mode_o     <= 2'b00;
            calib_timeout_o <= 1'b0;
        end else begin
            soc_rst_no <= (state_d == RUN);
            ready_o    <= (state_d == RUN);
            if (latch_boot) begin
                boot_mode_o <= boot_s;
            end
            if (set_timeout) begin
                calib_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_rst_seq.sv
// tb_soc_rst_seq: scoreboard bench for soc_rst_seq. Stimulus code pushes
// the expected output word for a given cycle number; a monitor on the
// falling edge pops each entry when that cycle arrives and compares.

`timescale 1ns/1ps

module tb_soc_rst_seq;

    logic       clk_i;
    logic       rst_ni;
    logic       locked_i;
    logic       calib_done_i;
    logic       btn_i;
    logic [1:0] boot_mode_i;
    logic       soc_rst_no;
    logic [1:0] boot_mode_o;
    logic       ready_o;
    logic       calib_timeout_o;

    soc_rst_seq #(
        .SyncStages     (2),
        .DebounceCycles (4),
        .HoldCycles     (8),
        .CalibTimeout   (32),
        .BtnActiveLow   (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .locked_i        (locked_i),
        .calib_done_i    (calib_done_i),
        .btn_i           (btn_i),
        .boot_mode_i     (boot_mode_i),
        .soc_rst_no      (soc_rst_no),
        .boot_mode_o     (boot_mode_o),
        .ready_o         (ready_o),
        .calib_timeout_o (calib_timeout_o)
    );

    // Output word: {soc_rst_no, ready_o, calib_timeout_o, boot_mode_o}
    typedef struct {
        string       tag;
        int unsigned cyc;
        logic [4:0]  val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc;
    int          n_vec;
    int          n_err;
    logic [4:0]  obs;

    assign obs = {soc_rst_no, ready_o, calib_timeout_o, boot_mode_o};

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Edge count since the last reset release.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic expect_at(input string tag, input int unsigned c, input logic [4:0] v);
        exp_t e;
        e.tag = tag;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Return 1 ns after the posedge that makes cyc reach n.
    task automatic step_to(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor, sampling midway between active edges.
    always @(negedge clk_i) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc == cyc) check(mon_e.tag, 32'(obs), 32'(mon_e.val));
            else                  check({mon_e.tag, "_missed"}, cyc, mon_e.cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_ni       = 1'b0;
        locked_i     = 1'b0;
        calib_done_i = 1'b0;
        btn_i        = 1'b1;
        boot_mode_i  = 2'b10;
        #23;
        check("reset_state", 32'(obs), 32'h0);
        rst_ni = 1'b1;

        // Clean boot: lock after 10, calib after 20 -> release at 31.
        expect_at("wait_lock",   5, 5'b00000);
        expect_at("boot_pre",   30, 5'b00000);
        expect_at("boot_rel",   31, 5'b11010);
        step_to(10); locked_i = 1'b1;
        step_to(20); calib_done_i = 1'b1;

        // Switch isolation in RUN.
        expect_at("sw_iso", 40, 5'b11010);
        step_to(33); boot_mode_i = 2'b01;

        // Bouncing button: toggles every 2 cycles, no reset.
        expect_at("bounce_a", 50, 5'b11010);
        expect_at("bounce_b", 60, 5'b11010);
        expect_at("bounce_c", 66, 5'b11010);
        for (int i = 0; i < 10; i++) begin
            step_to(41 + 2 * i);
            btn_i = (i % 2 == 1);
        end

        // Stable press after 70: reset at 77, HOLD 8 cycles, relatch 2'b01.
        expect_at("press_pre",  76, 5'b11010);
        expect_at("press_rst",  77, 5'b00010);
        expect_at("hold_last",  84, 5'b00010);
        expect_at("hold_rel",   85, 5'b11001);
        expect_at("release_ok",100, 5'b11001);
        step_to(70); btn_i = 1'b0;
        step_to(90); btn_i = 1'b1;

        // Lock loss after 105 -> reset at 108; relock after 115 -> RUN at 127.
        expect_at("lockloss_pre", 107, 5'b11001);
        expect_at("lockloss_rst", 108, 5'b00001);
        expect_at("relock_hold",  126, 5'b00001);
        expect_at("relock_rel",   127, 5'b11011);
        step_to(105); locked_i = 1'b0; boot_mode_i = 2'b11;
        step_to(115); locked_i = 1'b1;

        // Drive into HOLD again, then pulse the async reset.
        expect_at("relock2_wait", 133, 5'b00011);
        step_to(130); locked_i = 1'b0;
        step_to(140); locked_i = 1'b1;
        step_to(147);
        wait_drain(20);
        #2 rst_ni = 1'b0;
        #1 rst_ni = 1'b1;
        #1 check("async_rst", 32'(obs), 32'h0);

        // Sequence restarts with lock and calib already high.
        expect_at("restart_a",  2, 5'b00000);
        expect_at("restart_b", 11, 5'b00000);
        expect_at("restart_c", 12, 5'b11011);

        // Calibration timeout: calib low, relock after 30 -> WAIT_CALIB at 33,
        // HOLD + flag at 65, release at 73; late calib leaves the flag set.
        expect_at("to_pre",   64, 5'b00011);
        expect_at("to_set",   65, 5'b00111);
        expect_at("to_hold",  72, 5'b00111);
        expect_at("to_rel",   73, 5'b11101);
        expect_at("to_stick", 90, 5'b11101);
        step_to(20); locked_i = 1'b0; calib_done_i = 1'b0; boot_mode_i = 2'b01;
        step_to(30); locked_i = 1'b1;
        step_to(80); calib_done_i = 1'b1;
        wait_drain(40);

        // Power-on reset clears the sticky flag.
        #2 rst_ni = 1'b0;
        #1 check("final_rst", 32'(obs), 32'h0);
        rst_ni = 1'b1;
        #20;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/soc_rst_seq.md
# soc_rst_seq

Reset and boot-strap sequencer sitting directly upstream of the Cheshire SoC on the Xilinx targets. It synchronises the clock-wizard `locked`, DRAM calibration-done, board reset button and boot-mode switches into `soc_clk` and releases the SoC reset only after the clock is locked, DRAM is calibrated (or timed out) and a hold window has elapsed. It latches `boot_mode` at the moment of release. Its outputs drive `rst_ni` and `boot_mode_i` of `cheshire_soc`.

## Interface
- `SyncStages`, 2: flop stages on every asynchronous input (≥2).
- `DebounceCycles`, 50000: consecutive stable cycles before the button level is accepted (1 ms at 50 MHz); ≥1.
- `HoldCycles`, 256: cycles reset stays asserted in HOLD; ≥1.
- `CalibTimeout`, 2**24: cycles to wait for calibration; 0 disables the timeout (wait forever).
- `BtnActiveLow`, 1: 1 means `btn_i`=0 is a press.
- `clk_i` in 1: `soc_clk`, single clock domain.
- `rst_ni` in 1: asynchronous, active-low reset (power-on only, never driven by this block's outputs).
- `locked_i` in 1: clock-wizard lock, async.
- `calib_done_i` in 1: DRAM calibration complete, async; tie 1 when no DDR.
- `btn_i` in 1: board reset button, async, bouncing.
- `boot_mode_i` in 2: boot-mode switches, async.
- `soc_rst_no` out 1: registered SoC reset, active-low.
- `boot_mode_o` out 2: boot mode latched at release.
- `ready_o` out 1: 1 while in RUN.
- `calib_timeout_o` out 1: sticky, set when release happened because of timeout.

## Operation
- Synchronisers: `locked_i`, `calib_done_i`, `btn_i` and each `boot_mode_i` bit pass through `SyncStages` flops, reset to 0. `btn_i` reset to the released level.
- Debouncer: counter restarts on any change of the synced button. The debounced level `btn_db` takes the synced value when the counter reaches `DebounceCycles-1` with the input unchanged. A press event is the single-cycle transition of `btn_db` to pressed.
- FSM states: WAIT_LOCK (reset state), WAIT_CALIB, HOLD, RUN. One shared counter, width `$clog2` of the largest of `HoldCycles` and `CalibTimeout`, plus 1. The counter clears on every state change.
- WAIT_LOCK: go to WAIT_CALIB when synced lock = 1.
- WAIT_CALIB:
  - Go to HOLD when synced calib = 1.
  - If `CalibTimeout`≠0 and the counter reaches `CalibTimeout-1` with calib still 0, go to HOLD and set `calib_timeout_o`.
  - Calib and timeout in the same cycle: calib wins and the flag is not set.
- HOLD: go to RUN when the counter reaches `HoldCycles-1`. On that same edge, `boot_mode_o` takes the synced switches.
- RUN: stays until an event below.
- Priority, evaluated in every state except WAIT_LOCK:
  1. Synced lock = 0 → WAIT_LOCK.
  2. Otherwise, a press event → HOLD.
  3. Otherwise, the state rules above.
- A press event outside RUN restarts the HOLD counter if in HOLD, and is ignored in WAIT_CALIB.
- `calib_timeout_o` clears only on `rst_ni`. A later calib=1 does not clear it.
- Switch changes while in RUN do not affect `boot_mode_o`.

## Timing
- Reset values: `soc_rst_no`=0, `boot_mode_o`=0, `ready_o`=0, `calib_timeout_o`=0, state WAIT_LOCK, counters 0.
- `soc_rst_no` and `ready_o` are registered copies of (state==RUN). They rise on the clock edge that enters RUN and fall on the edge that leaves it. No combinational path from any input to any output.
- `locked_i` rising → WAIT_CALIB: `SyncStages`+1 edges.
- `calib_done_i` rising → HOLD: `SyncStages`+1 edges.
- HOLD → RUN: exactly `HoldCycles` cycles in HOLD.
- `locked_i` falling in RUN → `soc_rst_no`=0 after `SyncStages`+1 edges.
- Button press held stable → `soc_rst_no`=0 after `SyncStages` + `DebounceCycles` + 1 edges. Reset then holds for `HoldCycles` cycles, even if the button stays pressed. A release does not trigger a new hold.
- `rst_ni` asserted mid-operation: all outputs return to reset values immediately (asynchronously) and the full sequence restarts.

## Test plan
Common parameters: `SyncStages`=2, `DebounceCycles`=4, `HoldCycles`=8, `CalibTimeout`=32.
- Clean boot: `boot_mode_i`=2'b10, `locked_i`↑ at cycle 10, `calib_done_i`↑ at cycle 20 → `soc_rst_no`/`ready_o`=1 at cycle 31, `boot_mode_o`=2'b10, `calib_timeout_o`=0.
- Calib timeout: `locked_i`=1, `calib_done_i` held 0 → HOLD after 32 cycles in WAIT_CALIB, `calib_timeout_o`=1, release 8 cycles later. `calib_done_i`↑ afterwards leaves the flag at 1.
- Button bounce: in RUN, toggle `btn_i` every 2 cycles for 20 cycles → `soc_rst_no` stays 1. Then a stable press → `soc_rst_no`=0 after 7 cycles, back to 1 after 8 cycles. `boot_mode_o` relatched from the current switches.
- Lock loss: in RUN, drop `locked_i` → `soc_rst_no`=0 after 3 cycles, `ready_o`=0. Re-lock with calib=1 → full WAIT_CALIB/HOLD sequence replays.
- Switch isolation: change `boot_mode_i` to 2'b01 while in RUN → `boot_mode_o` unchanged.
- Async reset mid-HOLD: pulse `rst_ni` low for 1 ns between edges → all outputs 0 immediately and the state machine restarts in WAIT_LOCK.
